// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI slave receiver with synchronized pins and received-byte FIFO
//
// Receives MSB-first bytes from an SPI master whose pins are asynchronous to clk.
// Each byte is stored in a FIFO together with the DC flag that was present on its
// last bit.
// Optional feature macro: SPI_SLAVE_RX_FRAME_ERR_EN adds the frame_err_cnt output.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sample_posedge  1 = sample MOSI on SCLK rise, 0 = on SCLK fall
//   spi_sclk/mosi/cs_n/dc   raw SPI pins
//   rx_valid/rx_data/rx_dc  FIFO head; popped when rx_valid && rx_ready
//   rx_count        FIFO occupancy
//   overflow        sticky dropped-byte flag, cleared by clr_overflow
//   frame_err_cnt   (macro only) saturating count of discarded partial bytes
module spi_slave_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sample_posedge,
    input  logic                             spi_sclk,
    input  logic                             spi_mosi,
    input  logic                             spi_cs_n,
    input  logic                             spi_dc,
    output logic                             rx_valid,
    output logic [7:0]                       rx_data,
    output logic                             rx_dc,
    input  logic                             rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
    output logic                             overflow,
    input  logic                             clr_overflow
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    ,
    output logic [7:0]                       frame_err_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, dc_sync;
    // Fills with ones after reset; its MSB marks the point where the
    // synchronizer outputs reflect the real pins instead of reset values.
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_prev;
    logic                   armed_q;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic [8:0]             mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;

    logic sclk_s, mosi_s, cs_s, dc_s, flushed;
    logic sel_edge, shifting, byte_done, abort, full, pop, do_push, ovf_set;
    logic [7:0] new_byte;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign dc_s    = dc_sync[SYNC_STAGES-1];
    assign flushed = fill[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            dc_sync   <= '0;
            fill      <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
        end
    end

    // A frame already running at reset release must be skipped, so capture is
    // only enabled once a genuine (post-flush) cs_n high has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else if (flushed && cs_s) begin
            armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !cs_s) state_d = SHIFT;
            SHIFT:   if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sel_edge  = sample_posedge ? (sclk_s && !sclk_prev) : (!sclk_s && sclk_prev);
    assign shifting  = (state_q == SHIFT) && !cs_s && sel_edge;
    assign byte_done = shifting && (bit_cnt == 3'd7);
    assign new_byte  = {shift_q[6:0], mosi_s};
    assign abort     = (state_q == SHIFT) && cs_s && (bit_cnt != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            shift_q <= 8'h00;
        end else if ((state_q == SHIFT) && cs_s) begin
            bit_cnt <= 3'd0;
        end else if (shifting) begin
            shift_q <= new_byte;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign full     = (rx_count == CW'(FIFO_DEPTH));
    assign rx_valid = (rx_count != '0);
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = byte_done && (!full || pop);
    assign ovf_set  = byte_done && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {dc_s, new_byte};
        end
    end

    // Storage is not reset; the head is forced to zero while the FIFO is empty.
    assign rx_data = rx_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign rx_dc   = rx_valid ? mem[rd_ptr][8]   : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_cnt <= 8'h00;
        end else if (abort) begin
            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'h01;
        end else if (clr_overflow) begin
            frame_err_cnt <= 8'h00;
        end
    end
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed self-checking bench for spi_slave_rx
module tb_spi_slave_rx;

    logic       clk, rst, sample_posedge;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_dc;
    logic       rx_valid, rx_dc, rx_ready, overflow, clr_overflow;
    logic [7:0] rx_data;
    logic [3:0] rx_count;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic [7:0] frame_err_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    spi_slave_rx #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_posedge (sample_posedge),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_cs_n       (spi_cs_n),
        .spi_dc         (spi_dc),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_dc          (rx_dc),
        .rx_ready       (rx_ready),
        .rx_count       (rx_count),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        ,
        .frame_err_cnt  (frame_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All delays are multiples of 10 ns, so every drive/sample lands on a clk fall.
    task automatic send_bit(input logic b);
        if (sample_posedge) begin
            spi_mosi = b;
            #20 spi_sclk = 1'b1;
            #20 spi_sclk = 1'b0;
        end else begin
            spi_sclk = 1'b1;
            spi_mosi = b;
            #20 spi_sclk = 1'b0;
            #20;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        #40;
    endtask

    task automatic frame_end();
        #40 spi_cs_n = 1'b1;
        #60;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic dcv);
        chk({tag, "_valid"}, rx_valid, 1'b1);
        chk({tag, "_data"}, rx_data, d);
        chk({tag, "_dc"}, rx_dc, dcv);
        rx_ready = 1'b1;
        #10 rx_ready = 1'b0;
    endtask

    // Raises rx_ready for exactly the cycle in which the byte is pushed.
    task automatic pop_on_push();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            #10;
            if (dut.byte_done) found = 1'b1;
        end
        chk("push_seen", found, 1'b1);
        if (found) begin
            rx_ready = 1'b1;
            #10 rx_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; sample_posedge = 1'b1;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; spi_dc = 1'b0;
        rx_ready = 1'b0; clr_overflow = 1'b0;
        #20;
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_count", rx_count, 4'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_dc", rx_dc, 1'b0);
        rst = 1'b0;
        #100;

        // Four back-to-back command bytes, rising-edge sampling.
        frame_begin();
        send_byte(8'hAE); send_byte(8'hA1); send_byte(8'hC8); send_byte(8'hAF);
        frame_end();
        chk("t1_count", rx_count, 4'd4);
        chk("t1_ovf", overflow, 1'b0);
        pop_check("t1_p0", 8'hAE, 1'b0);
        pop_check("t1_p1", 8'hA1, 1'b0);
        pop_check("t1_p2", 8'hC8, 1'b0);
        pop_check("t1_p3", 8'hAF, 1'b0);
        chk("t1_empty", rx_valid, 1'b0);

        // Fill with data bytes, then overflow with a ninth.
        spi_dc = 1'b1;
        frame_begin();
        for (int k = 0; k < 8; k++) send_byte(8'(k * 8'h11));
        #40;
        chk("t2_count8", rx_count, 4'd8);
        chk("t2_ovf0", overflow, 1'b0);
        send_byte(8'h88);
        frame_end();
        chk("t2_ovf1", overflow, 1'b1);
        chk("t2_count", rx_count, 4'd8);
        chk("t2_head", rx_data, 8'h00);
        chk("t2_head_dc", rx_dc, 1'b1);

        clr_overflow = 1'b1;
        #10 clr_overflow = 1'b0;
        chk("t3_clr", overflow, 1'b0);

        // Push into a full FIFO with a pop in the same cycle.
        frame_begin();
        fork
            send_byte(8'h99);
            pop_on_push();
        join
        frame_end();
        chk("t3_count", rx_count, 4'd8);
        chk("t3_ovf", overflow, 1'b0);
        for (int k = 1; k < 8; k++) pop_check("t3_p", 8'(k * 8'h11), 1'b1);
        pop_check("t3_tail", 8'h99, 1'b1);
        chk("t3_empty", rx_valid, 1'b0);

        // Partial byte discarded, following full byte kept.
        spi_dc = 1'b0;
        frame_begin();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        frame_end();
        chk("t4_partial", rx_count, 4'd0);
        frame_begin();
        send_byte(8'h5A);
        frame_end();
        chk("t4_count", rx_count, 4'd1);
        pop_check("t4_p", 8'h5A, 1'b0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        chk("t4_ferr", frame_err_cnt, 8'd1);
`endif

        // Falling-edge sampling, then reset in the middle of a byte.
        sample_posedge = 1'b0;
        frame_begin();
        send_byte(8'h3C);
        frame_end();
        chk("t5_count", rx_count, 4'd1);
        chk("t5_data", rx_data, 8'h3C);
        frame_begin();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        rst = 1'b1;
        #20 rst = 1'b0;
        chk("t5_rst_count", rx_count, 4'd0);
        chk("t5_rst_valid", rx_valid, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        frame_end();
        chk("t5_ignored", rx_count, 4'd0);
        spi_dc = 1'b1;
        frame_begin();
        send_byte(8'hA5);
        frame_end();
        chk("t5_count2", rx_count, 4'd1);
        pop_check("t5_p", 8'hA5, 1'b1);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        chk("t5_ferr", frame_err_cnt, 8'd0);
`endif
        chk("t5_ovf", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of received-byte entries (power of 2, at least 2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per asynchronous pin input (at least 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port sample_posedge  input  1  1 = sample MOSI on SCLK rising edge; 0 = sample on falling edge; static while spi_cs_n is low.
REQ-006 SHALL have port spi_sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-007 SHALL have port spi_mosi  input  1  serial data, MSB first.
REQ-008 SHALL have port spi_cs_n  input  1  active-low frame select.
REQ-009 SHALL have port spi_dc  input  1  data/command flag (0 = command, 1 = data).
REQ-010 SHALL have port rx_valid  output  1  FIFO head entry available.
REQ-011 SHALL have port rx_data  output  8  FIFO head byte.
REQ-012 SHALL have port rx_dc  output  1  DC value captured with the head byte.
REQ-013 SHALL have port rx_ready  input  1  consumer pop strobe; a pop occurs when rx_valid and rx_ready are both high.
REQ-014 SHALL have port rx_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-016 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-017 SHALL pass spi_sclk, spi_mosi, spi_cs_n and spi_dc each through SYNC_STAGES flops before any use.
REQ-018 SHALL detect the selected SCLK edge from the last synchronized SCLK sample and the previous one.
REQ-019 SHALL support SCLK frequency up to clk/4; behaviour at higher SCLK rates is undefined.
REQ-020 SHALL implement an FSM with states IDLE and SHIFT:
- IDLE to SHIFT when synchronized cs_n is low.
- SHIFT to IDLE when synchronized cs_n is high.
REQ-021 SHALL, in SHIFT, on each selected edge, shift the synchronized MOSI into the LSB of an 8-bit shift register and increment a 3-bit bit counter.
REQ-022 SHALL, on the 8th edge (bit counter wraps 7 to 0), form the byte {shift[6:0], mosi} and capture synchronized dc with it.
REQ-023 SHALL write that entry into the FIFO so that rx_valid is high on the next cycle if the FIFO was empty.
REQ-024 SHALL continue receiving back-to-back bytes with cs_n held low; no gap between bytes is required.
REQ-025 SHALL, on cs_n deasserting with the bit counter nonzero, discard the partial byte.
REQ-026 SHALL clear the bit counter whenever the FSM enters IDLE.
REQ-027 SHALL, when a push occurs while the FIFO is full with no pop in the same cycle, drop the byte, set overflow and leave FIFO contents unchanged.
REQ-028 SHALL, on a simultaneous push and pop when full, perform both, keep rx_count at FIFO_DEPTH and leave overflow unchanged.
REQ-029 SHALL, on a simultaneous push and pop when empty, push only; the pop is ignored because rx_valid is low.
REQ-030 SHALL provide rx_data and rx_dc as the FIFO head, stable while rx_valid is high and no pop occurs.
REQ-031 SHALL give clr_overflow priority below a same-cycle overflow set (set wins).
REQ-032 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-033 SHALL, on rst, immediately force: FSM to IDLE, bit counter 0, shift register 0, FIFO pointers 0, rx_count 0, rx_valid 0, rx_data 0, rx_dc 0, overflow 0, synchronizer flops to the idle levels (sclk 0, mosi 0, cs_n 1, dc 0).
REQ-034 SHALL, on rst asserted mid-byte or mid-frame, lose all partial and buffered data.
REQ-035 SHALL, after reset release, wait for synchronized cs_n high-then-low before capturing; a frame already in progress is ignored.

Configuration
REQ-036 SHALL, when SPI_SLAVE_RX_FRAME_ERR_EN is defined, add output frame_err_cnt [7:0]: reset 0, +1 per partial-byte discard (REQ-025), saturating at 255, cleared together with overflow by clr_overflow.
REQ-037 SHALL, when SPI_SLAVE_RX_FRAME_ERR_EN is undefined, have no frame_err_cnt port and no counter logic.

Verification
REQ-038 SHALL cover: sample_posedge=1, SCLK=clk/4, cs_n low, DC=0, bytes AE A1 C8 AF -> FIFO pops AE,A1,C8,AF all rx_dc=0; overflow=0.
REQ-039 SHALL cover: DC=1, 8 bytes 00..77 (step 0x11), rx_ready held 0 -> rx_count=8, overflow=0; 9th byte 88 -> overflow=1, head still 00, last entry 77.
REQ-040 SHALL cover: rx_count=8, pop in the same cycle as a 9th byte push -> rx_count stays 8, overflow=0, new tail byte present.
REQ-041 SHALL cover: 5 bits sent then cs_n high, then full byte 5A -> only 5A received; frame_err_cnt=1 when SPI_SLAVE_RX_FRAME_ERR_EN is defined.
REQ-042 SHALL cover: sample_posedge=0, byte 3C on falling edges -> 3C received; rst pulsed mid-byte -> rx_count=0, rx_valid=0, next full frame received correctly.
